// File: rtl/ld_down_counter.sv
// Loadable, cascadable down counter/timer slice with terminal-count pulse and borrow ripple.
// Build option: define LD_DOWN_COUNTER_AUTORELOAD_EN for periodic auto-reload; otherwise one-shot.
module ld_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] D,
  input  logic             SD,
  input  logic             SCLR,
  input  logic             SP,
  input  logic             BI,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next, state_count;
  logic [WIDTH-1:0] rld, rld_next, q_next, q_count;
  logic             tc_next, tc_count;
  logic             dec, q_zero, underflow;

  assign q_zero    = (Q == '0);
  assign dec       = (state == RUN) & SP & BI;
  assign underflow = dec & q_zero;

  // Combinational borrow so a whole cascade decrements on the same edge.
  assign BO   = (state == RUN) & BI & q_zero;
  assign BUSY = (state == RUN);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    q_count     = Q;
    state_count = state;
    tc_count    = 1'b0;
    if (underflow) begin
      tc_count = 1'b1;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
      q_count     = rld;
      state_count = RUN;
`else
      q_count     = Q;
      state_count = DONE;
`endif
    end else if (dec) begin
      q_count = Q - WIDTH'(1);
    end

    // Ternaries (not if/else) so an unknown SD/SCLR propagates X into the count in simulation.
    q_next     = SCLR ? '0    : (SD ? D   : q_count);
    rld_next   = SCLR ? rld   : (SD ? D   : rld);
    state_next = SCLR ? IDLE  : (SD ? RUN : state_count);
    tc_next    = SCLR ? 1'b0  : (SD ? 1'b0 : tc_count);
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state <= IDLE;
      Q     <= '0;
      rld   <= '0;
      TC    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= state_next;
      Q     <= q_next;
      rld   <= rld_next;
      TC    <= tc_next;
    end
  end

endmodule

// File: tb/tb_ld_down_counter.sv
// Self-checking bench for ld_down_counter: a single slice plus a two-slice cascade,
// compared every edge against a rule-level reference model (honours LD_DOWN_COUNTER_AUTORELOAD_EN).
module tb_ld_down_counter;
  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         ck = 1'b0;
  logic         rst_n;
  logic [W-1:0] d, q;
  logic         sd, sclr, sp, bi, bo, tc, busy;

  logic [W-1:0] lo_d, hi_d, lo_q, hi_q;
  logic         c_sd, c_sclr, c_sp;
  logic         lo_bo, hi_bo, lo_tc, hi_tc, lo_busy, hi_busy;

  int n_pass  = 0;
  int n_total = 0;

  ld_down_counter #(.WIDTH(W)) dut (
    .CK(ck), .CDN(rst_n), .D(d), .SD(sd), .SCLR(sclr), .SP(sp), .BI(bi),
    .Q(q), .BO(bo), .TC(tc), .BUSY(busy)
  );

  ld_down_counter #(.WIDTH(W)) u_lo (
    .CK(ck), .CDN(rst_n), .D(lo_d), .SD(c_sd), .SCLR(c_sclr), .SP(c_sp), .BI(1'b1),
    .Q(lo_q), .BO(lo_bo), .TC(lo_tc), .BUSY(lo_busy)
  );

  ld_down_counter #(.WIDTH(W)) u_hi (
    .CK(ck), .CDN(rst_n), .D(hi_d), .SD(c_sd), .SCLR(c_sclr), .SP(c_sp), .BI(lo_bo),
    .Q(hi_q), .BO(hi_bo), .TC(hi_tc), .BUSY(hi_busy)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    int q;
    int rld;
    int mode;
    bit tc;
  } mstate_t;

  mstate_t m, m_lo, m_hi;

  function automatic mstate_t mreset();
    mstate_t s;
    s.q = 0; s.rld = 0; s.mode = M_IDLE; s.tc = 1'b0;
    return s;
  endfunction

  // One clock edge of the counter, straight from the behavioural rules.
  function automatic mstate_t mstep(mstate_t s, bit sclr_i, bit sd_i, bit sp_i, bit bi_i, int d_i);
    mstate_t n = s;
    n.tc = 1'b0;
    if (sclr_i) begin
      n.mode = M_IDLE;
      n.q    = 0;
    end else if (sd_i) begin
      n.q    = d_i;
      n.rld  = d_i;
      n.mode = M_RUN;
    end else if (s.mode == M_RUN && sp_i && bi_i) begin
      if (s.q == 0) begin
        n.tc = 1'b1;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
        n.q = s.rld;
`else
        n.mode = M_DONE;
`endif
      end else begin
        n.q = (s.q + M - 1) % M;
      end
    end
    return n;
  endfunction

  function automatic bit mbo(mstate_t s, bit bi_i);
    return (s.mode == M_RUN) && bi_i && (s.q == 0);
  endfunction

  function automatic logic [W+2:0] exp_single();
    logic [W-1:0] qv;
    qv = m.q[W-1:0];
    return {qv, m.tc, (m.mode == M_RUN), mbo(m, bi)};
  endfunction

  function automatic logic [2*W+1:0] exp_cascade();
    logic [W-1:0] hq, lq;
    hq = m_hi.q[W-1:0];
    lq = m_lo.q[W-1:0];
    return {hq, lq, m_hi.tc, m_lo.tc};
  endfunction

  // Advance every model by one edge using the inputs currently driven, then settle past the edge.
  task automatic tick();
    mstate_t nlo;
    m   = mstep(m, sclr, sd, sp, bi, int'(d));
    nlo = mstep(m_lo, c_sclr, c_sd, c_sp, 1'b1, int'(lo_d));
    m_hi = mstep(m_hi, c_sclr, c_sd, c_sp, mbo(m_lo, 1'b1), int'(hi_d));
    m_lo = nlo;
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d = '0; sd = 0; sclr = 0; sp = 0; bi = 0;
    lo_d = '0; hi_d = '0; c_sd = 0; c_sclr = 0; c_sp = 0;
    m = mreset(); m_lo = mreset(); m_hi = mreset();
    #12;
    n_total++;
    if ({q, tc, busy, bo} !== {{W{1'b0}}, 3'b000}) $display("FAIL reset_state got=%h want=%h", {q, tc, busy, bo}, {{W{1'b0}}, 3'b000});
    else n_pass++;
    @(negedge ck);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_async_clear();
    d = 4'd5; sd = 1; tick();
    sd = 0; sp = 0; bi = 1; tick();
    n_total++;
    if ({q, tc, busy, bo} !== exp_single()) $display("FAIL async_pre got=%h want=%h", {q, tc, busy, bo}, exp_single());
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({q, tc, busy} !== {{W{1'b0}}, 2'b00}) $display("FAIL async_clear got=%h want=%h", {q, tc, busy}, {{W{1'b0}}, 2'b00});
    else n_pass++;
    m = mreset(); m_lo = mreset(); m_hi = mreset();
    #2 rst_n = 1'b1;
    sp = 1; bi = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({q, tc, busy, bo} !== exp_single()) $display("FAIL async_idle[%0d] got=%h want=%h", i, {q, tc, busy, bo}, exp_single());
      else n_pass++;
    end
  endtask

  task automatic test_interval();
    int first_tc = 0;
    d = 4'd3; sd = 1; tick();
    sd = 0; sp = 1; bi = 1;
    for (int e = 2; e <= 13; e++) begin
      tick();
      if (tc && first_tc == 0) first_tc = e;
      n_total++;
      if ({q, tc, busy, bo} !== exp_single()) $display("FAIL interval[%0d] got=%h want=%h", e, {q, tc, busy, bo}, exp_single());
      else n_pass++;
    end
    n_total++;
    if (first_tc !== 5) $display("FAIL interval_tc_edge got=%0d want=5", first_tc);
    else n_pass++;
  endtask

  task automatic test_sp_gating();
    d = 4'd2; sd = 1; sp = 0; tick();
    sd = 0; bi = 1;
    for (int i = 0; i < 12; i++) begin
      sp = (i % 2 == 0);
      tick();
      n_total++;
      if ({q, tc, busy, bo} !== exp_single()) $display("FAIL sp_gating[%0d] got=%h want=%h", i, {q, tc, busy, bo}, exp_single());
      else n_pass++;
    end
  endtask

  task automatic test_cascade();
    lo_d = 4'd0; hi_d = 4'd1; c_sd = 1; c_sp = 1; tick();
    c_sd = 0;
    n_total++;
    if ({hi_q, lo_q, lo_bo} !== {4'd1, 4'd0, 1'b1}) $display("FAIL cascade_load got=%h want=%h", {hi_q, lo_q, lo_bo}, {4'd1, 4'd0, 1'b1});
    else n_pass++;
    tick();
    n_total++;
    if ({hi_q, lo_q, hi_tc, lo_tc} !== exp_cascade()) $display("FAIL cascade_first got=%h want=%h", {hi_q, lo_q, hi_tc, lo_tc}, exp_cascade());
    else n_pass++;
    lo_d = W'($urandom); hi_d = W'($urandom_range(1, 3)); c_sd = 1; tick();
    c_sd = 0;
    for (int i = 0; i < 60; i++) begin
      c_sp = ($urandom_range(0, 3) != 0);
      tick();
      n_total++;
      if ({hi_q, lo_q, hi_tc, lo_tc} !== exp_cascade()) $display("FAIL cascade_run[%0d] got=%h want=%h", i, {hi_q, lo_q, hi_tc, lo_tc}, exp_cascade());
      else n_pass++;
    end
    c_sp = 0;
  endtask

  task automatic test_load_on_underflow();
    d = 4'd1; sd = 1; tick();
    sd = 0; sp = 1; bi = 1; tick();
    d = 4'd7; sd = 1; tick();
    sd = 0; sp = 0;
    n_total++;
    if ({q, tc, busy} !== {4'd7, 1'b0, 1'b1}) $display("FAIL load_on_underflow got=%h want=%h", {q, tc, busy}, {4'd7, 1'b0, 1'b1});
    else n_pass++;
    n_total++;
    if ({q, tc, busy, bo} !== exp_single()) $display("FAIL load_on_underflow_model got=%h want=%h", {q, tc, busy, bo}, exp_single());
    else n_pass++;
  endtask

  task automatic test_sclr();
    d = W'($urandom_range(4, M - 1)); sd = 1; tick();
    sd = 0; sp = 1; bi = 1; tick(); tick();
    sclr = 1; sd = 1; d = 4'd9; tick();
    sclr = 0; sd = 0;
    n_total++;
    if ({q, tc, busy} !== {{W{1'b0}}, 2'b00}) $display("FAIL sclr_over_sd got=%h want=%h", {q, tc, busy}, {{W{1'b0}}, 2'b00});
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      sp = 1'($urandom); bi = 1'($urandom);
      tick();
      n_total++;
      if ({q, tc, busy, bo} !== exp_single()) $display("FAIL sclr_idle[%0d] got=%h want=%h", i, {q, tc, busy, bo}, exp_single());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sclr = ($urandom_range(0, 24) == 0);
      sd   = ($urandom_range(0, 9) == 0);
      sp   = ($urandom_range(0, 3) != 0);
      bi   = ($urandom_range(0, 4) != 0);
      d    = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      tick();
      n_total++;
      if ({q, tc, busy, bo} !== exp_single()) $display("FAIL random[%0d] got=%h want=%h", i, {q, tc, busy, bo}, exp_single());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_interval();
    test_sp_gating();
    test_cascade();
    test_load_on_underflow();
    test_sclr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
